// File: rtl/ex_stage_mc.sv
// rtl/ex_stage_mc.sv - execute stage with valid/ready handshake and iterative multiplier
// Optional overflow trap enabled by defining EX_OVF_TRAP_EN (adds out_trap).
module ex_stage_mc #(
    parameter int XLEN      = 32,
    parameter int IR_W      = 32,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IR_W-1:0] in_ir,
    input  logic [XLEN-1:0] in_npc,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_op,
    input  logic            in_use_imm,
    input  logic            in_branch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu,
    output logic            out_zf,
    output logic            out_of,
    output logic            out_cond,
    output logic [XLEN-1:0] out_b,
    output logic [IR_W-1:0] out_ir,
`ifdef EX_OVF_TRAP_EN
    output logic            out_trap,
`endif
    output logic            out_busy
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int N_ITER = XLEN / MUL_RADIX;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [XLEN-1:0]     npc_q, npc_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     imm_q, imm_d;
    logic [2:0]          op_q, op_d;
    logic                use_imm_q, use_imm_d;
    logic                branch_q, branch_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept;
    logic [2*XLEN-1:0]   pp_sum;
    logic [XLEN-1:0]     opa, opb, sum, diff, res;
    logic                of_raw;

    assign out_valid = (state_q == ST_HOLD);
    assign out_busy  = (state_q == ST_MUL);
    assign in_ready  = !flush && (state_q != ST_MUL) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    // Partial products for this iteration: the multiplicand is pre-shifted each cycle.
    always_comb begin
        pp_sum = '0;
        for (int j = 0; j < MUL_RADIX; j++) begin
            if (mplier_q[j]) begin
                pp_sum = pp_sum + (mcand_q << j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        npc_d     = npc_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        op_d      = op_q;
        use_imm_d = use_imm_q;
        branch_d  = branch_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        if (flush) begin
            state_d = ST_IDLE;
            ir_d    = '1;
        end else begin
            case (state_q)
                ST_MUL: begin
                    acc_d    = acc_q + pp_sum;
                    mcand_d  = mcand_q << MUL_RADIX;
                    mplier_d = mplier_q >> MUL_RADIX;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    if (accept) begin
                        ir_d      = in_ir;
                        npc_d     = in_npc;
                        a_d       = in_a;
                        b_d       = in_b;
                        imm_d     = in_imm;
                        op_d      = in_branch ? OP_ADD : in_op;
                        use_imm_d = in_use_imm;
                        branch_d  = in_branch;
                        if (in_op == OP_MUL && !in_branch) begin
                            state_d  = ST_MUL;
                            acc_d    = '0;
                            mcand_d  = {{XLEN{1'b0}}, in_a};
                            mplier_d = in_use_imm ? in_imm : in_b;
                            cnt_d    = CNT_W'(N_ITER);
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else if (state_q == ST_HOLD && out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '1;
            npc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            op_q      <= OP_ADD;
            use_imm_q <= 1'b0;
            branch_q  <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            npc_q     <= npc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            op_q      <= op_d;
            use_imm_q <= use_imm_d;
            branch_q  <= branch_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

    // Branches compute npc + (imm << 2) through the adder.
    assign opa  = branch_q ? npc_q : a_q;
    assign opb  = branch_q ? (imm_q << 2) : (use_imm_q ? imm_q : b_q);
    assign sum  = opa + opb;
    assign diff = opa - opb;

    always_comb begin
        res    = '0;
        of_raw = 1'b0;
        case (op_q)
            OP_ADD: begin
                res    = sum;
                of_raw = (opa[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != opa[XLEN-1]);
            end
            OP_SUB: begin
                res    = diff;
                of_raw = (opa[XLEN-1] != opb[XLEN-1]) && (diff[XLEN-1] != opa[XLEN-1]);
            end
            OP_AND: res = opa & opb;
            OP_OR:  res = opa | opb;
            OP_XOR: res = opa ^ opb;
            OP_SLT: res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLL: res = opa << opb[4:0];
            default: begin
                res    = acc_q[XLEN-1:0];
                of_raw = |acc_q[2*XLEN-1:XLEN];
            end
        endcase
    end

`ifdef EX_OVF_TRAP_EN
    assign out_trap = out_valid && of_raw && (op_q == OP_ADD || op_q == OP_SUB);
    assign out_alu  = out_trap ? '0 : res;
`else
    assign out_alu  = res;
`endif

    // Flags only mean something alongside a valid result.
    assign out_zf   = out_valid && (out_alu == '0);
    assign out_of   = out_valid && of_raw;
    assign out_cond = out_valid && (a_q == '0);
    assign out_b    = b_q;
    assign out_ir   = ir_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb/tb_ex_stage_mc.sv - directed self-checking bench for ex_stage_mc (radix 1 and radix 4)
module tb_ex_stage_mc;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_ir, in_npc, in_a, in_b, in_imm;
    logic [2:0]  in_op;
    logic        in_use_imm, in_branch;

    logic        in_ready, out_valid, out_zf, out_of, out_cond, out_busy;
    logic [31:0] out_alu, out_b, out_ir;
    logic        in_ready_r4, out_valid_r4, out_zf_r4, out_of_r4, out_cond_r4, out_busy_r4;
    logic [31:0] out_alu_r4, out_b_r4, out_ir_r4;
`ifdef EX_OVF_TRAP_EN
    logic        out_trap, out_trap_r4;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.XLEN(32), .IR_W(32), .MUL_RADIX(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ir(in_ir), .in_npc(in_npc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_op(in_op), .in_use_imm(in_use_imm), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu(out_alu), .out_zf(out_zf),
        .out_of(out_of), .out_cond(out_cond), .out_b(out_b), .out_ir(out_ir),
`ifdef EX_OVF_TRAP_EN
        .out_trap(out_trap),
`endif
        .out_busy(out_busy)
    );

    ex_stage_mc #(.XLEN(32), .IR_W(32), .MUL_RADIX(4)) dut_r4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_r4),
        .in_ir(in_ir), .in_npc(in_npc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_op(in_op), .in_use_imm(in_use_imm), .in_branch(in_branch),
        .out_valid(out_valid_r4), .out_ready(out_ready), .out_alu(out_alu_r4), .out_zf(out_zf_r4),
        .out_of(out_of_r4), .out_cond(out_cond_r4), .out_b(out_b_r4), .out_ir(out_ir_r4),
`ifdef EX_OVF_TRAP_EN
        .out_trap(out_trap_r4),
`endif
        .out_busy(out_busy_r4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic use_imm, input logic br,
                        input logic [31:0] npc, input logic [31:0] ir);
        in_op = op; in_a = a; in_b = b; in_imm = imm; in_use_imm = use_imm;
        in_branch = br; in_npc = npc; in_ir = ir; in_valid = 1'b1;
        #1;
        check("send_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic check_result(input string tag, input logic [31:0] alu, input logic zf,
                                input logic of, input logic cond);
        check({tag, "_valid"}, out_valid, 1);
`ifdef EX_OVF_TRAP_EN
        if (of && (in_op == 3'd0 || in_op == 3'd1) && !in_branch) begin
            check({tag, "_trap"}, out_trap, 1);
            check({tag, "_alu"}, out_alu, 0);
        end else begin
            check({tag, "_alu"}, out_alu, alu);
            check({tag, "_zf"}, out_zf, zf);
        end
`else
        check({tag, "_alu"}, out_alu, alu);
        check({tag, "_zf"}, out_zf, zf);
`endif
        check({tag, "_of"}, out_of, of);
        check({tag, "_cond"}, out_cond, cond);
    endtask

    task automatic mul_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic exp_of);
        int busy1 = 0, busy4 = 0, early = 0;
        logic seen1 = 1'b0, seen4 = 1'b0;
        logic [31:0] alu1 = 32'hDEAD_BEEF, alu4 = 32'hDEAD_BEEF;
        logic of1 = 1'b0, of4 = 1'b0;
        send(3'd7, a, b, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0707);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        for (int i = 0; i < 40; i++) begin
            if (out_busy) busy1++;
            if (out_busy_r4) busy4++;
            if (out_busy && out_valid) early++;
            if (out_valid && !seen1) begin seen1 = 1'b1; alu1 = out_alu; of1 = out_of; end
            if (out_valid_r4 && !seen4) begin seen4 = 1'b1; alu4 = out_alu_r4; of4 = out_of_r4; end
            tick();
        end
        check({tag, "_busy_r1"}, busy1, 32);
        check({tag, "_busy_r4"}, busy4, 8);
        check({tag, "_valid_while_busy"}, early, 0);
        check({tag, "_seen_r1"}, seen1, 1);
        check({tag, "_seen_r4"}, seen4, 1);
        check({tag, "_alu_r1"}, alu1, exp_lo);
        check({tag, "_of_r1"}, of1, exp_of);
        check({tag, "_alu_r4"}, alu4, exp_lo);
        check({tag, "_of_r4"}, of4, exp_of);
    endtask

    task automatic watch_no_valid(input string tag);
        int nv = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) nv++;
            tick();
        end
        check(tag, nv, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_busy"}, out_busy, 0);
        check({tag, "_ir"}, out_ir, 32'hFFFF_FFFF);
        check({tag, "_alu"}, out_alu, 0);
        check({tag, "_zf"}, out_zf, 0);
        check({tag, "_of"}, out_of, 0);
        check({tag, "_cond"}, out_cond, 0);
        check({tag, "_b"}, out_b, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ir = '0; in_npc = '0; in_a = '0; in_b = '0; in_imm = '0;
        in_op = '0; in_use_imm = 1'b0; in_branch = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("reset");

        send(3'd0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0011);
        check_result("add", 32'd12, 1'b0, 1'b0, 1'b0);
        check("add_ir", out_ir, 32'h0000_0011);
        check("add_b", out_b, 32'd7);

        send(3'd1, 32'h1234, 32'h1234, 32'd0, 1'b0, 1'b0, 32'd0, 32'h22);
        check_result("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
        send(3'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h23);
        check_result("sub_cond", 32'd0, 1'b1, 1'b0, 1'b1);

        send(3'd0, 32'd10, 32'h99, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'd0, 32'h24);
        check_result("add_imm", 32'd7, 1'b0, 1'b0, 1'b0);
        check("add_imm_b", out_b, 32'h99);
        send(3'd4, 32'd9, 32'd0, 32'd4, 1'b0, 1'b1, 32'h100, 32'h25);
        check_result("branch", 32'h110, 1'b0, 1'b0, 1'b0);
        send(3'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'h26);
        check_result("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        send(3'd6, 32'd3, 32'h24, 32'd0, 1'b0, 1'b0, 32'd0, 32'h27);
        check_result("sll", 32'h30, 1'b0, 1'b0, 1'b0);
        send(3'd2, 32'hF0F0, 32'hFF00, 32'd0, 1'b0, 1'b0, 32'd0, 32'h28);
        check_result("and", 32'hF000, 1'b0, 1'b0, 1'b0);

        send(3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'h29);
        check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(3'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'h2A);
        check_result("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        tick();

        mul_run("mul_big", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
        mul_run("mul_small", 32'd6, 32'd7, 32'd42, 1'b0);

        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 32'h44);
        check_result("hold_first", 32'd3, 1'b0, 1'b0, 1'b0);
        in_op = 3'd0; in_a = 32'd10; in_b = 32'd20; in_ir = 32'h55; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_in_ready", in_ready, 0);
            check("hold_alu", out_alu, 32'd3);
            check("hold_ir", out_ir, 32'h44);
            check("hold_valid", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        check_result("release_next", 32'd30, 1'b0, 1'b0, 1'b0);
        check("release_ir", out_ir, 32'h55);
        tick();

        send(3'd7, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'h66);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        check("flush_busy_before", out_busy, 1);
        tick();
        flush = 1'b0;
        #1;
        check("flush_valid", out_valid, 0);
        check("flush_busy", out_busy, 0);
        check("flush_ir", out_ir, 32'hFFFF_FFFF);
        check("flush_in_ready_after", in_ready, 1);
        watch_no_valid("flush_no_result");

        send(3'd7, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'h77);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_state("rst_mid");
        watch_no_valid("rst_no_result");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
